// File: rtl/fp16_argmax_reader.sv
// rtl/fp16_argmax_reader.sv - snapshot an FP16 vector and report the 1-based argmax of its positive elements
//
// Purpose: sits after fp16_softmax. A rising edge of in_valid captures the packed
// vector. The block then scans one element per clock and reports the index and
// value of the largest positive, non-NaN element. The result is held until clear.
//
// Ports:
//   clk         rising-edge clock
//   reset_b     asynchronous active-low reset
//   in_valid    softmax valid (level); only its rising edge starts a run
//   clear       synchronous one-cycle clear; aborts a scan or acknowledges a result
//   neuron_val  packed FP16 vector, element i at [i*16 +: 16]
//   busy        high while scanning
//   done        high from result ready until clear/reset
//   max_index   1-based index of the maximum, 0 when no element is positive
//   max_val     FP16 value of the maximum, 0 when max_index is 0

module fp16_argmax_reader #(
    parameter int IN_OUT_NUM = 10,
    parameter int IDX_W      = $clog2(IN_OUT_NUM + 1)
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     in_valid,
    input  logic                     clear,
    input  logic [IN_OUT_NUM*16-1:0] neuron_val,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         max_index,
    output logic [15:0]              max_val
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(IN_OUT_NUM - 1);

    state_t                    state_q,     state_d;
    logic                      in_valid_q,  in_valid_d;
    logic [IN_OUT_NUM*16-1:0]  snapshot_q,  snapshot_d;
    logic [IDX_W-1:0]          ptr_q,       ptr_d;
    logic [IDX_W-1:0]          run_idx_q,   run_idx_d;
    logic [15:0]               run_val_q,   run_val_d;
    logic                      busy_q,      busy_d;
    logic                      done_q,      done_d;
    logic [IDX_W-1:0]          max_index_q, max_index_d;
    logic [15:0]               max_val_q,   max_val_d;

    logic        start;
    logic [15:0] elem;
    logic        elem_nan;
    logic        elem_wins;
    logic [IDX_W-1:0] ptr_inc;

    assign start     = in_valid & ~in_valid_q;
    assign elem      = snapshot_q[16*int'(ptr_q) +: 16];
    assign elem_nan  = (elem[14:10] == 5'h1F) && (elem[9:0] != 10'd0);
    // Running max starts at +0 and the compare is strict, so negatives, zeros
    // and later equal values never displace the current winner. For positive
    // FP16 the raw magnitude bits order the same way as the values.
    assign elem_wins = !elem[15] && !elem_nan && (elem[14:0] > run_val_q[14:0]);
    assign ptr_inc   = ptr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        in_valid_d  = in_valid;
        snapshot_d  = snapshot_q;
        ptr_d       = ptr_q;
        run_idx_d   = run_idx_q;
        run_val_d   = run_val_q;
        busy_d      = busy_q;
        done_d      = done_q;
        max_index_d = max_index_q;
        max_val_d   = max_val_q;

        if (clear) begin
            // Clear beats a same-cycle start; in_valid_q still tracks in_valid,
            // so a held valid cannot retrigger until it falls and rises again.
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            max_index_d = '0;
            max_val_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        snapshot_d  = neuron_val;
                        ptr_d       = '0;
                        run_idx_d   = '0;
                        run_val_d   = '0;
                        max_index_d = '0;
                        max_val_d   = '0;
                        busy_d      = 1'b1;
                        state_d     = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (elem_wins) begin
                        run_val_d = elem;
                        run_idx_d = ptr_inc;
                    end
                    ptr_d = ptr_inc;
                    if (ptr_q == LAST_PTR) begin
                        // Publish the winner including the element judged this cycle.
                        max_index_d = elem_wins ? ptr_inc : run_idx_q;
                        max_val_d   = elem_wins ? elem    : run_val_q;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= ST_IDLE;
            in_valid_q  <= 1'b0;
            snapshot_q  <= '0;
            ptr_q       <= '0;
            run_idx_q   <= '0;
            run_val_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            max_index_q <= '0;
            max_val_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_valid_q  <= in_valid_d;
            snapshot_q  <= snapshot_d;
            ptr_q       <= ptr_d;
            run_idx_q   <= run_idx_d;
            run_val_q   <= run_val_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            max_index_q <= max_index_d;
            max_val_q   <= max_val_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign max_index = max_index_q;
    assign max_val   = max_val_q;

endmodule

// File: tb/tb_fp16_argmax_reader.sv
// tb/tb_fp16_argmax_reader.sv - self-checking bench for fp16_argmax_reader

module tb_fp16_argmax_reader;

    localparam int N     = 10;
    localparam int IDX_W = $clog2(N + 1);

    logic             clk;
    logic             reset_b;
    logic             in_valid;
    logic             clear;
    logic [N*16-1:0]  neuron_val;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] max_index;
    logic [15:0]      max_val;

    int checks;
    int errors;

    logic [15:0] vec [N];

    fp16_argmax_reader #(.IN_OUT_NUM(N), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .in_valid   (in_valid),
        .clear      (clear),
        .neuron_val (neuron_val),
        .busy       (busy),
        .done       (done),
        .max_index  (max_index),
        .max_val    (max_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*16-1:0] pack_vec();
        logic [N*16-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i*16 +: 16] = vec[i];
        return p;
    endfunction

    // Classifier decision: largest strictly positive real number (Inf counts,
    // NaN does not); on equal values the first occurrence is kept.
    function automatic bit is_positive_number(logic [15:0] e);
        bit is_nan;
        is_nan = (e[14:10] == 5'h1F) && (e[9:0] != 0);
        return (e[15] == 1'b0) && !is_nan && (e[14:0] != 0);
    endfunction

    function automatic void ref_argmax(output int idx, output logic [15:0] val);
        idx = 0;
        val = 16'h0000;
        for (int i = 0; i < N; i++) begin
            if (is_positive_number(vec[i]) && (idx == 0 || vec[i][14:0] > val[14:0])) begin
                idx = i + 1;
                val = vec[i];
            end
        end
    endfunction

    task automatic scramble_input();
        logic [15:0] r;
        for (int i = 0; i < N; i++) begin
            r = 16'($urandom());
            neuron_val[i*16 +: 16] = r;
        end
    endtask

    task automatic check_outputs(string name, logic exp_busy, logic exp_done,
                                 int exp_idx, logic [15:0] exp_val);
        checks++;
        if (busy !== exp_busy || done !== exp_done ||
            max_index !== IDX_W'(exp_idx) || max_val !== exp_val) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b idx=%0d val=%h, expected busy=%b done=%b idx=%0d val=%h",
                     name, busy, done, max_index, max_val, exp_busy, exp_done, exp_idx, exp_val);
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || max_index !== '0 || max_val !== 16'h0) begin
            errors++;
            $display("FAIL clear_ack: got busy=%b done=%b idx=%0d val=%h, expected all 0",
                     busy, done, max_index, max_val);
        end
    endtask

    // Full run from the IDLE state with in_valid low beforehand.
    task automatic run_check(string name);
        int          exp_idx;
        logic [15:0] exp_val;
        ref_argmax(exp_idx, exp_val);
        @(posedge clk); #1;
        neuron_val = pack_vec();
        in_valid   = 1'b1;
        @(posedge clk); #1;                      // capture edge
        check_outputs({name, "_capture"}, 1'b1, 1'b0, 0, 16'h0);
        scramble_input();                        // must not affect the result
        for (int k = 1; k < N; k++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s_scan%0d: got busy=%b done=%b, expected busy=1 done=0",
                         name, k, busy, done);
            end
        end
        @(posedge clk); #1;                      // edge N
        check_outputs({name, "_result"}, 1'b0, 1'b1, exp_idx, exp_val);
        // A new rising in_valid in DONE is ignored; the result holds.
        in_valid = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        scramble_input();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_outputs({name, "_hold"}, 1'b0, 1'b1, exp_idx, exp_val);
        pulse_clear();
    endtask

    task automatic test_reset();
        reset_b    = 1'b0;
        in_valid   = 1'b1;
        clear      = 1'b0;
        neuron_val = '1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset_held", 1'b0, 1'b0, 0, 16'h0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset_b = 1'b1;
        repeat (N + 3) @(posedge clk);
        #1;
        check_outputs("reset_release_no_run", 1'b0, 1'b0, 0, 16'h0);
    endtask

    task automatic test_nominal();
        for (int i = 0; i < N; i++) vec[i] = 16'h2E66;
        vec[6] = 16'h399A;
        run_check("nominal");
    endtask

    task automatic test_tie();
        for (int i = 0; i < N; i++) vec[i] = 16'h3800;
        vec[2] = 16'h3C00;
        vec[5] = 16'h3C00;
        run_check("tie");
    endtask

    task automatic test_non_positive();
        for (int i = 0; i < N; i++) vec[i] = 16'hBC00;
        run_check("all_negative");
        for (int i = 0; i < N; i++) vec[i] = (i % 2 == 0) ? 16'h0000 : 16'h8000;
        run_check("all_zero");
    endtask

    task automatic test_special_values();
        vec[0] = 16'h7E00;
        for (int i = 1; i < N - 1; i++) vec[i] = 16'hC000;
        vec[N-1] = 16'h3400;
        run_check("nan_skip");
        vec[4] = 16'h7C00;
        run_check("pos_inf");
        for (int i = 0; i < N; i++) vec[i] = 16'h0001 + 16'(i % 3);
        run_check("subnormal");
    endtask

    task automatic test_abort_retrigger();
        for (int i = 0; i < N; i++) vec[i] = 16'h3000 + 16'(i);
        @(posedge clk); #1;
        neuron_val = pack_vec();
        in_valid   = 1'b1;
        @(posedge clk); #1;                      // capture edge
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b1;                            // sampled at the 4th scan edge
        @(posedge clk); #1;
        clear = 1'b0;
        check_outputs("abort_now", 1'b0, 1'b0, 0, 16'h0);
        repeat (N + 2) @(posedge clk);
        #1;
        check_outputs("abort_no_restart", 1'b0, 1'b0, 0, 16'h0);
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) vec[i] = 16'h2000;
        vec[8] = 16'h3555;
        run_check("retrigger");

        // clear and start in the same cycle: no run, and a held valid never retriggers
        @(posedge clk); #1;
        neuron_val = pack_vec();
        in_valid   = 1'b1;
        clear      = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_outputs("clear_start_same", 1'b0, 1'b0, 0, 16'h0);
        repeat (N + 2) @(posedge clk);
        #1;
        check_outputs("clear_start_no_run", 1'b0, 1'b0, 0, 16'h0);
        in_valid = 1'b0;

        // reset mid-scan returns everything to zero immediately
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        reset_b = 1'b0;
        #1;
        check_outputs("reset_mid_scan", 1'b0, 1'b0, 0, 16'h0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset_b = 1'b1;
        repeat (N + 2) @(posedge clk);
        #1;
        check_outputs("after_reset_idle", 1'b0, 1'b0, 0, 16'h0);
    endtask

    task automatic test_random();
        int kind;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                kind = $urandom_range(0, 5);
                case (kind)
                    0: vec[i] = 16'($urandom());
                    1: vec[i] = 16'h3000 + 16'($urandom_range(0, 16'h0C00));
                    2: vec[i] = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
                    3: vec[i] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
                    4: vec[i] = ($urandom_range(0, 1) != 0) ? 16'h7C00
                                                             : (16'h7C00 | 16'($urandom_range(1, 16'h03FF)));
                    default: vec[i] = (i > 0) ? vec[i-1] : 16'h3C00;
                endcase
            end
            run_check("random");
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_b    = 1'b0;
        in_valid   = 1'b0;
        clear      = 1'b0;
        neuron_val = '0;
        test_reset();
        test_nominal();
        test_tie();
        test_non_positive();
        test_special_values();
        test_abort_retrigger();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
